// File: rtl/pingpong_reg_file_if.sv
// rtl/pingpong_reg_file_if.sv - producer/consumer bus of the ping-pong register file
interface pingpong_reg_file_if #(
  parameter int PORT_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int NUM_READ_PORTS = 2,
  parameter int BLOCK_WORDS    = 2
);
  localparam int BLK_W  = ADDR_WIDTH - $clog2(BLOCK_WORDS);
  // A single-block bank still carries a one-bit (ignored) block address.
  localparam int BLK_WD = (BLK_W > 0) ? BLK_W : 1;

  logic                                 writeValid;
  logic                                 writeReady;
  logic [BLK_WD-1:0]                    writeAddrBlock;
  logic [PORT_WIDTH*BLOCK_WORDS-1:0]    writeData;
  logic                                 writeCommit;
  logic                                 readEnable;
  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readAddr;
  logic [NUM_READ_PORTS*PORT_WIDTH-1:0] readData;
  logic                                 readDataValid;
  logic                                 readBankValid;
  logic                                 readRelease;
  logic                                 writeBankIdx;
  logic                                 readBankIdx;

  modport master (
    output writeValid, writeAddrBlock, writeData, writeCommit,
    output readEnable, readAddr, readRelease,
    input  writeReady, readData, readDataValid, readBankValid,
    input  writeBankIdx, readBankIdx
  );

  modport slave (
    input  writeValid, writeAddrBlock, writeData, writeCommit,
    input  readEnable, readAddr, readRelease,
    output writeReady, readData, readDataValid, readBankValid,
    output writeBankIdx, readBankIdx
  );
endinterface

// File: rtl/pingpong_reg_file.sv
// rtl/pingpong_reg_file.sv - double-buffered register file with block writes and registered multi-port reads
module pingpong_reg_file #(
  parameter int PORT_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int NUM_READ_PORTS = 2,
  parameter int BLOCK_WORDS    = 2
) (
  input logic                clock,
  input logic                resetn,
  pingpong_reg_file_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int LANE_W = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;

  occ_t occ, occ_nxt;
  logic wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic write_ready, bank_valid;
  logic write_fire, commit_fire, read_fire, release_fire;
  logic [ADDR_WIDTH-1:0]                wr_base;
  logic [PORT_WIDTH-1:0]                mem [2][DEPTH];
  logic [NUM_READ_PORTS*PORT_WIDTH-1:0] read_data_q;
  logic                                 read_valid_q;

  assign write_ready  = (occ != OCC_FULL);
  assign bank_valid   = (occ != OCC_EMPTY);
  assign write_fire   = bus.writeValid && write_ready;
  assign commit_fire  = bus.writeCommit && write_ready;
  assign read_fire    = bus.readEnable && bank_valid;
  assign release_fire = bus.readRelease && bank_valid;
  assign wr_base      = ADDR_WIDTH'(bus.writeAddrBlock) << LANE_W;

  assign bus.writeReady    = write_ready;
  assign bus.readBankValid = bank_valid;
  assign bus.writeBankIdx  = wr_ptr;
  assign bus.readBankIdx   = rd_ptr;
  assign bus.readData      = read_data_q;
  assign bus.readDataValid = read_valid_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ    <= OCC_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      occ    <= occ_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Commit is gated off when full and release when empty, so occupancy never wraps.
  always_comb begin
    occ_nxt    = occ;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (commit_fire)  wr_ptr_nxt = ~wr_ptr;
    if (release_fire) rd_ptr_nxt = ~rd_ptr;
    case ({commit_fire, release_fire})
      2'b10:   occ_nxt = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_nxt = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (write_fire) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        mem[wr_ptr][wr_base | ADDR_WIDTH'(i)] <= bus.writeData[i*PORT_WIDTH +: PORT_WIDTH];
      end
    end
  end

  // The reader's bank is never the writer's while it is valid, so no bypass path is needed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= read_fire;
      if (read_fire) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
          read_data_q[p*PORT_WIDTH +: PORT_WIDTH] <= mem[rd_ptr][bus.readAddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        end
      end
    end
  end
endmodule

// File: tb/tb_pingpong_reg_file.sv
// tb/tb_pingpong_reg_file.sv - scoreboard bench for the ping-pong register file, default and wide builds
module tb_pingpong_reg_file;
  localparam int PW    = 16;
  localparam int AW_A  = 3;
  localparam int NR_A  = 2;
  localparam int BW_A  = 2;
  localparam int BLK_A = AW_A - $clog2(BW_A);
  localparam int AW_B  = 4;
  localparam int NR_B  = 4;
  localparam int BW_B  = 4;
  localparam int BLK_B = AW_B - $clog2(BW_B);

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  pingpong_reg_file_if #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW_A), .NUM_READ_PORTS(NR_A), .BLOCK_WORDS(BW_A)) bus_a ();
  pingpong_reg_file_if #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW_B), .NUM_READ_PORTS(NR_B), .BLOCK_WORDS(BW_B)) bus_b ();

  pingpong_reg_file #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW_A), .NUM_READ_PORTS(NR_A), .BLOCK_WORDS(BW_A))
    dut_a (.clock(clock), .resetn(resetn), .bus(bus_a));
  pingpong_reg_file #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW_B), .NUM_READ_PORTS(NR_B), .BLOCK_WORDS(BW_B))
    dut_b (.clock(clock), .resetn(resetn), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Reference model: two banks per instance, committed banks kept in hand-over order.
  logic [PW-1:0] bank_m [2][2][16];
  int            wr_bank [2];
  int            full_q0[$];
  int            full_q1[$];
  logic [63:0]   sb0[$];
  logic [63:0]   sb1[$];

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, inst, act, want);
    end
  endtask

  function automatic int occ(input int inst);
    return (inst == 0) ? full_q0.size() : full_q1.size();
  endfunction

  function automatic int rd_bank(input int inst);
    if (occ(inst) == 0) return wr_bank[inst];
    return (inst == 0) ? full_q0[0] : full_q1[0];
  endfunction

  always @(negedge clock) begin
    if (bus_a.readDataValid === 1'b1) begin
      if (sb0.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected[0]: readData %0h, want no pending read", bus_a.readData);
      end else check("rd_data", 0, 64'(bus_a.readData), sb0.pop_front());
    end
    if (bus_b.readDataValid === 1'b1) begin
      if (sb1.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected[1]: readData %0h, want no pending read", bus_b.readData);
      end else check("rd_data", 1, 64'(bus_b.readData), sb1.pop_front());
    end
  end

  task automatic idle_all();
    bus_a.writeValid = 1'b0; bus_a.writeAddrBlock = '0; bus_a.writeData = '0; bus_a.writeCommit = 1'b0;
    bus_a.readEnable = 1'b0; bus_a.readAddr = '0; bus_a.readRelease = 1'b0;
    bus_b.writeValid = 1'b0; bus_b.writeAddrBlock = '0; bus_b.writeData = '0; bus_b.writeCommit = 1'b0;
    bus_b.readEnable = 1'b0; bus_b.readAddr = '0; bus_b.readRelease = 1'b0;
  endtask

  task automatic model_reset();
    wr_bank[0] = 0;
    wr_bank[1] = 0;
    full_q0.delete();
    full_q1.delete();
    sb0.delete();
    sb1.delete();
  endtask

  // One clock of stimulus on one instance; model advances on the edge, outputs checked 1ns later.
  task automatic cyc(input int inst, input bit wv, input int blk, input logic [63:0] wd,
                     input bit cm, input bit re, input logic [63:0] ra, input bit rl);
    int aw, nr, bw, rb;
    bit rdy, bv, rd_fire;
    logic [63:0] want;
    aw = (inst == 0) ? AW_A : AW_B;
    nr = (inst == 0) ? NR_A : NR_B;
    bw = (inst == 0) ? BW_A : BW_B;
    rdy = occ(inst) < 2;
    bv = occ(inst) > 0;
    rb = rd_bank(inst);
    rd_fire = re && bv;
    if (inst == 0) begin
      bus_a.writeValid = wv; bus_a.writeAddrBlock = BLK_A'(blk); bus_a.writeData = wd[PW*BW_A-1:0];
      bus_a.writeCommit = cm; bus_a.readEnable = re; bus_a.readAddr = ra[NR_A*AW_A-1:0]; bus_a.readRelease = rl;
    end else begin
      bus_b.writeValid = wv; bus_b.writeAddrBlock = BLK_B'(blk); bus_b.writeData = wd[PW*BW_B-1:0];
      bus_b.writeCommit = cm; bus_b.readEnable = re; bus_b.readAddr = ra[NR_B*AW_B-1:0]; bus_b.readRelease = rl;
    end
    if (rd_fire) begin
      want = '0;
      for (int p = 0; p < nr; p++)
        want[p*PW +: PW] = bank_m[inst][rb][int'((ra >> (p*aw)) & ((64'd1 << aw) - 64'd1))];
      if (inst == 0) sb0.push_back(want); else sb1.push_back(want);
    end
    @(posedge clock);
    if (wv && rdy)
      for (int i = 0; i < bw; i++) bank_m[inst][wr_bank[inst]][blk*bw+i] = wd[i*PW +: PW];
    if (cm && rdy) begin
      if (inst == 0) full_q0.push_back(wr_bank[inst]); else full_q1.push_back(wr_bank[inst]);
      wr_bank[inst] = 1 - wr_bank[inst];
    end
    if (rl && bv) begin
      if (inst == 0) void'(full_q0.pop_front()); else void'(full_q1.pop_front());
    end
    #1;
    idle_all();
    check("writeReady", inst, 64'((inst == 0) ? bus_a.writeReady : bus_b.writeReady), 64'(occ(inst) < 2));
    check("readBankValid", inst, 64'((inst == 0) ? bus_a.readBankValid : bus_b.readBankValid), 64'(occ(inst) > 0));
    check("writeBankIdx", inst, 64'((inst == 0) ? bus_a.writeBankIdx : bus_b.writeBankIdx), 64'(wr_bank[inst]));
    check("readBankIdx", inst, 64'((inst == 0) ? bus_a.readBankIdx : bus_b.readBankIdx), 64'(rd_bank(inst)));
    check("readDataValid", inst, 64'((inst == 0) ? bus_a.readDataValid : bus_b.readDataValid), 64'(rd_fire));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    idle_all();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    check("rst_writeReady", 0, 64'(bus_a.writeReady), 64'd1);
    check("rst_readBankValid", 0, 64'(bus_a.readBankValid), 64'd0);
    check("rst_readDataValid", 0, 64'(bus_a.readDataValid), 64'd0);
    check("rst_readData", 0, 64'(bus_a.readData), 64'd0);
    check("rst_bank_idx", 0, 64'({bus_a.writeBankIdx, bus_a.readBankIdx}), 64'd0);

    // fill bank0 with {2k+1,2k}, commit, read words 5/6
    for (int k = 0; k < 4; k++) cyc(0, 1, k, 64'({16'(2*k+1), 16'(2*k)}), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    check("fill_writeBankIdx", 0, 64'(bus_a.writeBankIdx), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 64'((6 << AW_A) | 5), 0);
    check("fill_read", 0, 64'(bus_a.readData), 64'h0006_0005);

    // backpressure: fill bank1, no release; dropped write and commit
    for (int k = 0; k < 4; k++) cyc(0, 1, k, 64'({16'(256+2*k+1), 16'(256+2*k)}), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    check("full_writeReady", 0, 64'(bus_a.writeReady), 64'd0);
    cyc(0, 1, 0, 64'hFFFF_FFFF, 1, 0, 0, 0);
    check("dropped_commit_idx", 0, 64'(bus_a.writeBankIdx), 64'd0);
    cyc(0, 0, 0, 0, 0, 1, 64'((1 << AW_A) | 0), 0);
    check("bank0_reread", 0, 64'(bus_a.readData), 64'h0001_0000);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("release_writeReady", 0, 64'(bus_a.writeReady), 64'd1);
    cyc(0, 0, 0, 0, 0, 1, 64'((1 << AW_A) | 0), 0);
    check("bank1_read", 0, 64'(bus_a.readData), 64'h0101_0100);

    // write and commit in the same cycle lands in the old bank
    cyc(0, 1, 3, 64'hAAAA_BBBB, 1, 0, 0, 0);
    check("wc_writeBankIdx", 0, 64'(bus_a.writeBankIdx), 64'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 64'((7 << AW_A) | 6), 0);
    check("wc_read", 0, 64'(bus_a.readData), 64'hAAAA_BBBB);

    // simultaneous commit and release with one bank committed
    cyc(0, 0, 0, 0, 1, 0, 0, 1);
    check("cr_readBankValid", 0, 64'(bus_a.readBankValid), 64'd1);
    check("cr_bank_idx", 0, 64'({bus_a.writeBankIdx, bus_a.readBankIdx}), 64'b01);

    // read while empty is ignored and readData holds
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 64'($urandom), 0);
    check("empty_read_hold", 0, 64'(bus_a.readData), 64'hAAAA_BBBB);

    // read with same-cycle release uses the released bank
    cyc(0, 1, 0, 64'h1234_5678, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 64'((1 << AW_A) | 0), 1);
    check("read_release", 0, 64'(bus_a.readData), 64'h1234_5678);

    // asynchronous reset while a read result is being presented
    cyc(0, 1, 2, {$urandom, $urandom}, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 64'((5 << AW_A) | 4), 0);
    #1 resetn = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 0, 64'(bus_a.readDataValid), 64'd0);
    check("async_rst_data", 0, 64'(bus_a.readData), 64'd0);
    check("async_rst_idx", 0, 64'({bus_a.readBankValid, bus_a.writeBankIdx, bus_a.readBankIdx}), 64'd0);
    @(posedge clock);
    #1 resetn = 1'b1;

    // wide build: 100 banks filled, read at random addresses, released
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < 4; k++) cyc(1, 1, k, {$urandom, $urandom}, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 0, 0);
      for (int r = 0; r < 3; r++)
        cyc(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), {$urandom, $urandom},
            0, 1'($urandom_range(0, 1)) | (r == 2), {$urandom, $urandom}, r == 2);
    end

    repeat (2) @(negedge clock);
    check("sb_drained", 0, 64'(sb0.size()), 64'd0);
    check("sb_drained", 1, 64'(sb1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
